// File: rtl/common_tag_release_merge.sv
// Staging buffer between the commit side (up to two released tags per cycle)
// and the single write port of the free-list FIFO; drains one tag per cycle.
module common_tag_release_merge #(
  parameter int TAG_WIDTH = 6,
  parameter int BUF_DEPTH = 4,
  localparam int PTR_W = $clog2(BUF_DEPTH),
  localparam int CNT_W = $clog2(BUF_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [TAG_WIDTH-1:0] in0_tag,
  input  logic                 in0_valid,
  input  logic [TAG_WIDTH-1:0] in1_tag,
  input  logic                 in1_valid,
  output logic                 in_ready,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_wen,
  input  logic                 fifo_full,
  output logic [CNT_W-1:0]     occupancy
);

  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [TAG_WIDTH-1:0] stage_q [BUF_DEPTH];
  logic [TAG_WIDTH-1:0] stage_d [BUF_DEPTH];
  logic [1:0]           n_acc;

  always_comb begin
    // NOTE: every signal gets a default at the top so no path leaves one unassigned and infers a latch.
    stage_d = stage_q;
    n_acc   = 2'd0;

    // Ready looks only at the registered count, so upstream never sees a
    // combinational path through fifo_full.
    in_ready = (count_q <= CNT_W'(BUF_DEPTH - 2));
    out_wen  = (count_q != '0) && !fifo_full;
    out_tag  = stage_q[head_q];

    if (in_ready) begin
      n_acc = {1'b0, in0_valid} + {1'b0, in1_valid};
      if (in0_valid) stage_d[tail_q] = in0_tag;
      // A lone in1 lands at tail; behind in0 it lands at tail+1.
      if (in1_valid) stage_d[tail_q + PTR_W'(in0_valid)] = in1_tag;
    end

    tail_d  = tail_q + PTR_W'(n_acc);
    head_d  = head_q + PTR_W'(out_wen);
    count_d = count_q + CNT_W'(n_acc) - CNT_W'(out_wen);
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the tag storage is deliberately not reset; count_q = 0 makes its contents irrelevant.
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign occupancy = count_q;

endmodule

// File: tb/tb_common_tag_release_merge.sv
// Directed bench for common_tag_release_merge: a vector table for the single-cycle
// behaviour plus a wrap-around stream checked against a small queue model.
module tb_common_tag_release_merge;

  localparam int TAG_WIDTH = 6;
  localparam int BUF_DEPTH = 4;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 reset;
  logic [TAG_WIDTH-1:0] in0_tag, in1_tag;
  logic                 in0_valid, in1_valid;
  logic                 in_ready;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 out_wen;
  logic                 fifo_full;
  logic [CNT_W-1:0]     occupancy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  common_tag_release_merge #(
    .TAG_WIDTH(TAG_WIDTH),
    .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in0_tag  (in0_tag),
    .in0_valid(in0_valid),
    .in1_tag  (in1_tag),
    .in1_valid(in1_valid),
    .in_ready (in_ready),
    .out_tag  (out_tag),
    .out_wen  (out_wen),
    .fifo_full(fifo_full),
    .occupancy(occupancy)
  );

  // Inputs for one cycle and the outputs expected during that same cycle.
  typedef struct {
    logic       rst;
    logic       v0;
    logic [5:0] t0;
    logic       v1;
    logic [5:0] t1;
    logic       ff;
    logic       rdy;
    logic       wen;
    logic [5:0] tag;
    int         occ;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic v0, input int t0, input logic v1, input int t1,
                     input logic ff, input logic rdy, input logic wen, input int tag, input int occ);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.t0 = 6'(t0); v.v1 = v1; v.t1 = 6'(t1);
    v.ff = ff; v.rdy = rdy; v.wen = wen; v.tag = 6'(tag); v.occ = occ;
    vecs.push_back(v);
  endtask

  initial begin
    int next_tag;
    int pair;
    int cyc;
    int model_cnt;

    reset = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;
    in0_tag = '0; in1_tag = '0; fifo_full = 1'b0;
    @(negedge clk);
    @(negedge clk);

    //   rst v0 t0  v1 t1  ff  rdy wen tag occ
    // single tag after reset
    add(0, 1, 20, 0, 0,  0,  1,  0,  0,  0);
    add(0, 0, 0,  0, 0,  0,  1,  1,  20, 1);
    add(0, 0, 0,  0, 0,  0,  1,  0,  0,  0);
    // dual ordering
    add(0, 1, 33, 1, 34, 0,  1,  0,  0,  0);
    add(0, 0, 0,  0, 0,  0,  1,  1,  33, 2);
    add(0, 0, 0,  0, 0,  0,  1,  1,  34, 1);
    add(0, 0, 0,  0, 0,  0,  1,  0,  0,  0);
    // backpressure: third pair 44/45 held until ready returns
    add(0, 1, 40, 1, 41, 1,  1,  0,  0,  0);
    add(0, 1, 42, 1, 43, 1,  1,  0,  0,  2);
    add(0, 1, 44, 1, 45, 1,  0,  0,  0,  4);
    add(0, 1, 44, 1, 45, 1,  0,  0,  0,  4);
    add(0, 1, 44, 1, 45, 0,  0,  1,  40, 4);
    add(0, 1, 44, 1, 45, 0,  0,  1,  41, 3);
    add(0, 1, 44, 1, 45, 0,  1,  1,  42, 2);
    add(0, 0, 0,  0, 0,  0,  0,  1,  43, 3);
    add(0, 0, 0,  0, 0,  0,  1,  1,  44, 2);
    add(0, 0, 0,  0, 0,  0,  1,  1,  45, 1);
    add(0, 0, 0,  0, 0,  0,  1,  0,  0,  0);
    // lone in1
    add(0, 0, 0,  1, 7,  0,  1,  0,  0,  0);
    add(0, 0, 0,  0, 0,  0,  1,  1,  7,  1);
    add(0, 0, 0,  0, 0,  0,  1,  0,  0,  0);
    // reset mid-operation with occupancy 3 and a pair presented
    add(0, 1, 50, 1, 51, 1,  1,  0,  0,  0);
    add(0, 1, 52, 0, 0,  1,  1,  0,  0,  2);
    add(1, 1, 53, 1, 54, 1,  0,  0,  0,  3);
    add(0, 0, 0,  0, 0,  0,  1,  0,  0,  0);
    add(0, 0, 0,  0, 0,  0,  1,  0,  0,  0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      in0_valid = vecs[i].v0; in0_tag = vecs[i].t0;
      in1_valid = vecs[i].v1; in1_tag = vecs[i].t1;
      fifo_full = vecs[i].ff;
      #1;
      check($sformatf("vec%0d in_ready", i), int'(in_ready), int'(vecs[i].rdy));
      check($sformatf("vec%0d out_wen", i), int'(out_wen), int'(vecs[i].wen));
      check($sformatf("vec%0d occupancy", i), int'(occupancy), vecs[i].occ);
      if (vecs[i].wen) check($sformatf("vec%0d out_tag", i), int'(out_tag), int'(vecs[i].tag));
      @(negedge clk);
    end

    // Wrap-around: 10 pairs (0..19) with fifo_full toggling every cycle.
    reset = 1'b0;
    next_tag = 0; pair = 0; model_cnt = 0;
    for (cyc = 0; cyc < 200 && next_tag < 20; cyc++) begin
      logic exp_wen;
      logic exp_rdy;
      in0_valid = (pair < 10); in0_tag = 6'(2 * pair);
      in1_valid = (pair < 10); in1_tag = 6'(2 * pair + 1);
      fifo_full = cyc[0];
      #1;
      exp_rdy = (model_cnt <= BUF_DEPTH - 2);
      exp_wen = (model_cnt != 0) && !fifo_full;
      check("wrap in_ready", int'(in_ready), int'(exp_rdy));
      check("wrap out_wen", int'(out_wen), int'(exp_wen));
      if (exp_wen) begin
        check("wrap out_tag", int'(out_tag), next_tag);
        next_tag++;
        model_cnt--;
      end
      if (exp_rdy && pair < 10) begin
        pair++;
        model_cnt += 2;
      end
      @(negedge clk);
    end
    check("wrap tags drained", next_tag, 20);
    in0_valid = 1'b0; in1_valid = 1'b0; fifo_full = 1'b0;
    #1;
    check("wrap final occupancy", int'(occupancy), 0);
    check("wrap final out_wen", int'(out_wen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
